pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus: D/E/M hazard inputs, pipeline-register controls and MDU status.
interface pipe_hazard_ctrl_if;
  logic        d_load_use;
  logic        d_md_use;
  logic        e_md_start;
  logic        e_md_op;
  logic        m_flush_req;
  logic        fd_wren;
  logic        de_wren;
  logic        em_wren;
  logic        mw_wren;
  logic        fd_flush;
  logic        de_flush;
  logic        em_flush;
  logic        mw_flush;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic        md_done;
  logic [15:0] stall_cnt;

  modport master (
    output d_load_use, d_md_use, e_md_start, e_md_op, m_flush_req,
    input  fd_wren, de_wren, em_wren, mw_wren,
    input  fd_flush, de_flush, em_flush, mw_flush,
    input  md_busy, md_cnt, md_done, stall_cnt
  );

  modport slave (
    input  d_load_use, d_md_use, e_md_start, e_md_op, m_flush_req,
    output fd_wren, de_wren, em_wren, mw_wren,
    output fd_flush, de_flush, em_flush, mw_flush,
    output md_busy, md_cnt, md_done, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / MDU stalls, flushes, MDU busy timer and stall counter.
module pipe_hazard_ctrl (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 16;
  localparam logic [CNT_W-1:0]   MUL_CYCLES = CNT_W'(5);
  localparam logic [CNT_W-1:0]   DIV_CYCLES = CNT_W'(10);
  localparam logic [STALL_W-1:0] STALL_MAX  = {STALL_W{1'b1}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_md_cnt;
  logic                 r_md_done;
  logic [STALL_W-1:0]   r_stall_cnt;

  logic                 w_stall;
  logic                 w_fd_wren, w_de_wren, w_em_wren, w_mw_wren;
  logic                 w_fd_flush, w_de_flush, w_em_flush, w_mw_flush;

  assign w_stall = bus.d_load_use |
                   (bus.d_md_use & ((r_state == ST_BUSY) | bus.e_md_start));

  // MDU timer FSM and saturating stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_md_cnt    <= '0;
      r_md_done   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_md_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.e_md_start && !bus.m_flush_req) begin
            r_state  <= ST_BUSY;
            r_md_cnt <= bus.e_md_op ? DIV_CYCLES : MUL_CYCLES;
          end
        end
        ST_BUSY: begin
          // Flushes and new starts do not disturb an operation in flight
          if (r_md_cnt == CNT_W'(1)) begin
            r_state   <= ST_IDLE;
            r_md_cnt  <= '0;
            r_md_done <= 1'b1;
          end else begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_md_cnt <= '0;
        end
      endcase
      if (w_stall && !bus.m_flush_req && (r_stall_cnt != STALL_MAX)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
    end
  end

  // Zero-latency pipeline register control; reset beats flush beats stall
  always_comb begin
    w_fd_wren  = 1'b1;
    w_de_wren  = 1'b1;
    w_em_wren  = 1'b1;
    w_mw_wren  = 1'b1;
    w_fd_flush = 1'b0;
    w_de_flush = 1'b0;
    w_em_flush = 1'b0;
    w_mw_flush = 1'b0;
    if (!reset) begin
      w_fd_wren  = 1'b0;
      w_de_wren  = 1'b0;
      w_em_wren  = 1'b0;
      w_mw_wren  = 1'b0;
      w_fd_flush = 1'b1;
      w_de_flush = 1'b1;
      w_em_flush = 1'b1;
      w_mw_flush = 1'b1;
    end else if (bus.m_flush_req) begin
      w_fd_flush = 1'b1;
      w_de_flush = 1'b1;
      w_em_flush = 1'b1;
    end else if (w_stall) begin
      w_fd_wren  = 1'b0;
      w_de_flush = 1'b1;
    end
  end

  assign bus.fd_wren   = w_fd_wren;
  assign bus.de_wren   = w_de_wren;
  assign bus.em_wren   = w_em_wren;
  assign bus.mw_wren   = w_mw_wren;
  assign bus.fd_flush  = w_fd_flush;
  assign bus.de_flush  = w_de_flush;
  assign bus.em_flush  = w_em_flush;
  assign bus.mw_flush  = w_mw_flush;
  assign bus.md_busy   = (r_state == ST_BUSY);
  assign bus.md_cnt    = r_md_cnt;
  assign bus.md_done   = r_md_done;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_fail;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] wren_v();
    return {bus.fd_wren, bus.de_wren, bus.em_wren, bus.mw_wren};
  endfunction

  function automatic logic [3:0] flush_v();
    return {bus.fd_flush, bus.de_flush, bus.em_flush, bus.mw_flush};
  endfunction

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.d_load_use  = 1'b0;
    bus.d_md_use    = 1'b0;
    bus.e_md_start  = 1'b0;
    bus.e_md_op     = 1'b0;
    bus.m_flush_req = 1'b0;
    #2;

    // Reset state
    check("rst_busy",  16'(bus.md_busy), 16'h0);
    check("rst_cnt",   16'(bus.md_cnt), 16'h0);
    check("rst_done",  16'(bus.md_done), 16'h0);
    check("rst_stall", bus.stall_cnt, 16'h0);
    check("rst_wren",  16'(wren_v()), 16'h0);
    check("rst_flush", 16'(flush_v()), 16'hF);
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("idle_wren",  16'(wren_v()), 16'hF);
    check("idle_flush", 16'(flush_v()), 16'h0);

    // Multiply: 5 busy cycles counting 5..1, then one-cycle done
    bus.e_md_start = 1'b1;
    bus.e_md_op    = 1'b0;
    tick();
    bus.e_md_start = 1'b0;
    for (int i = 5; i >= 1; i--) begin
      check("mul_busy", 16'(bus.md_busy), 16'h1);
      check("mul_cnt",  16'(bus.md_cnt), 16'(i));
      check("mul_done", 16'(bus.md_done), 16'h0);
      tick();
    end
    check("mul_end_busy", 16'(bus.md_busy), 16'h0);
    check("mul_end_cnt",  16'(bus.md_cnt), 16'h0);
    check("mul_end_done", 16'(bus.md_done), 16'h1);
    tick();
    check("mul_done_drop", 16'(bus.md_done), 16'h0);

    // Divide with D-stage MDU use held: stall on start cycle plus 10 busy cycles
    bus.d_md_use   = 1'b1;
    bus.e_md_start = 1'b1;
    bus.e_md_op    = 1'b1;
    #1;
    check("div_start_fd_wren",  16'(bus.fd_wren), 16'h0);
    check("div_start_de_flush", 16'(bus.de_flush), 16'h1);
    tick();
    bus.e_md_start = 1'b0;
    bus.e_md_op    = 1'b0;
    for (int i = 10; i >= 1; i--) begin
      check("div_cnt",      16'(bus.md_cnt), 16'(i));
      check("div_fd_wren",  16'(bus.fd_wren), 16'h0);
      check("div_de_flush", 16'(bus.de_flush), 16'h1);
      tick();
    end
    check("div_end_busy",     16'(bus.md_busy), 16'h0);
    check("div_end_done",     16'(bus.md_done), 16'h1);
    check("div_stall_cnt",    bus.stall_cnt, 16'd11);
    check("div_end_de_flush", 16'(bus.de_flush), 16'h0);
    check("div_end_fd_wren",  16'(bus.fd_wren), 16'h1);
    bus.d_md_use = 1'b0;

    // Load-use together with flush: flush wins, no stall counted
    bus.d_load_use  = 1'b1;
    bus.m_flush_req = 1'b1;
    #1;
    check("lu_fl_flush", 16'(flush_v()), 16'hE);
    check("lu_fl_wren",  16'(wren_v()), 16'hF);
    tick();
    check("lu_fl_stall_cnt", bus.stall_cnt, 16'd11);
    bus.m_flush_req = 1'b0;
    #1;
    check("lu_flush", 16'(flush_v()), 16'h4);
    check("lu_wren",  16'(wren_v()), 16'h7);
    tick();
    check("lu_stall_cnt", bus.stall_cnt, 16'd12);
    bus.d_load_use = 1'b0;

    // Start suppressed by a concurrent flush in IDLE
    bus.e_md_start  = 1'b1;
    bus.m_flush_req = 1'b1;
    tick();
    check("fl_start_busy", 16'(bus.md_busy), 16'h0);
    bus.m_flush_req = 1'b0;

    // Multiply with a restart (as divide) at cnt=3 and a flush during BUSY
    bus.e_md_op = 1'b0;
    tick();
    bus.e_md_start = 1'b0;
    check("rst_mul_cnt5", 16'(bus.md_cnt), 16'd5);
    tick();
    tick();
    check("rst_mul_cnt3", 16'(bus.md_cnt), 16'd3);
    bus.e_md_start = 1'b1;
    bus.e_md_op    = 1'b1;
    tick();
    bus.e_md_start = 1'b0;
    bus.e_md_op    = 1'b0;
    check("no_reload_cnt", 16'(bus.md_cnt), 16'd2);
    bus.m_flush_req = 1'b1;
    tick();
    bus.m_flush_req = 1'b0;
    check("flush_busy_cnt", 16'(bus.md_cnt), 16'd1);
    check("flush_busy",     16'(bus.md_busy), 16'h1);
    tick();
    check("orig_sched_done", 16'(bus.md_done), 16'h1);
    check("orig_sched_busy", 16'(bus.md_busy), 16'h0);
    tick();

    // Async reset at cnt=6 of a divide
    bus.e_md_start = 1'b1;
    bus.e_md_op    = 1'b1;
    tick();
    bus.e_md_start = 1'b0;
    bus.e_md_op    = 1'b0;
    repeat (4) tick();
    check("ar_cnt6", 16'(bus.md_cnt), 16'd6);
    #2;
    reset = 1'b0;
    #1;
    check("ar_busy",  16'(bus.md_busy), 16'h0);
    check("ar_cnt",   16'(bus.md_cnt), 16'h0);
    check("ar_stall", bus.stall_cnt, 16'h0);
    check("ar_wren",  16'(wren_v()), 16'h0);
    check("ar_flush", 16'(flush_v()), 16'hF);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("ar_no_done", 16'(bus.md_done), 16'h0);
    end
    // First edge after release acts as IDLE
    @(negedge clk);
    reset = 1'b1;
    bus.e_md_start = 1'b1;
    tick();
    bus.e_md_start = 1'b0;
    check("post_rst_busy", 16'(bus.md_busy), 16'h1);
    check("post_rst_cnt",  16'(bus.md_cnt), 16'd5);
    check("post_rst_done", 16'(bus.md_done), 16'h0);
    repeat (6) tick();
    check("post_rst_idle", 16'(bus.md_busy), 16'h0);

    // Stall counter saturation
    bus.d_load_use = 1'b1;
    repeat (65534) tick();
    check("sat_fffe", bus.stall_cnt, 16'hFFFE);
    tick();
    check("sat_ffff", bus.stall_cnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_hold", bus.stall_cnt, 16'hFFFF);
    end
    bus.d_load_use = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
